ram512_sweep_ctrl: RTL
======================

RAM512_SWEEP_CTRL -- requirements
Module: ram512_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter DEPTH, default 512, giving the number of words swept per pass.
REQ-002 The module SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-003 The module SHALL have parameter ADDR_W, default 9, giving the address width, with DEPTH equal to 2**ADDR_W.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: request a pass, sampled only in IDLE.
REQ-007 The module SHALL have port abort, input, 1 bit: terminate the current pass.
REQ-008 The module SHALL have port verify, input, 1 bit: pass type, 0 = fill and 1 = verify; it is sampled with start.
REQ-009 The module SHALL have port incr, input, 1 bit: pattern select, 0 = constant seed and 1 = seed + index; it is sampled with start.
REQ-010 The module SHALL have port seed, input, WIDTH bits: pattern base, sampled with start.
REQ-011 The module SHALL have port ram_out, input, WIDTH bits: the RAM512 combinational read data.
REQ-012 The module SHALL have port ram_in, output, WIDTH bits: write data to the RAM512 in port.
REQ-013 The module SHALL have port ram_load, output, 1 bit: write enable to the RAM512 load port.
REQ-014 The module SHALL have port ram_address, output, ADDR_W bits: address to the RAM512 address port.
REQ-015 The module SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-016 The module SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-017 The module SHALL have port err_count, output, ADDR_W+1 bits: number of mismatches found in the last verify pass.
REQ-018 The module SHALL have port first_err_addr, output, ADDR_W bits: address of the first mismatch.
REQ-019 The module SHALL have port err_flag, output, 1 bit: high when err_count is nonzero.

Function
REQ-020 The FSM SHALL have the states IDLE, FILL, VERIFY and DONE.
REQ-021 When start=1 and abort=0 are sampled in IDLE at edge k, the FSM SHALL latch verify, incr and seed, clear the index to 0, and enter FILL (verify=0) or VERIFY (verify=1).
REQ-022 busy SHALL be high from cycle k+1 through cycle k+DEPTH, and ram_address SHALL equal the index, stepping 0..DEPTH-1 at one word per cycle.
REQ-023 The expected word SHALL be seed when incr=0, or (seed + zero-extended index) mod 2**WIDTH when incr=1.
REQ-024 ram_in SHALL carry the expected word whenever busy=1, and SHALL be 0 in IDLE and DONE.
REQ-025 In FILL, ram_load SHALL be 1; in all other states ram_load SHALL be 0.
REQ-026 In VERIFY, ram_out SHALL be compared with the expected word in the same cycle, and on a mismatch err_count SHALL increment at the next edge.
REQ-027 On the first mismatch of a pass, first_err_addr SHALL capture that address; later mismatches SHALL leave first_err_addr unchanged.
REQ-028 After index DEPTH-1 the FSM SHALL enter DONE for exactly one cycle (done=1, busy=0) and then return to IDLE; the index SHALL NOT wrap within a pass.
REQ-029 err_count, first_err_addr and err_flag SHALL be cleared on each accepted start and SHALL hold their values after DONE until the next start.
REQ-030 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-031 abort=1 in FILL or VERIFY SHALL return the FSM to IDLE at the next edge with no done pulse and no further write; error outputs SHALL keep their partial values.
REQ-032 abort and start both high in IDLE SHALL leave the FSM in IDLE.
REQ-033 A start sampled in the DONE cycle SHALL be ignored.

Reset
REQ-034 RST_N=0 SHALL, asynchronously, force IDLE and drive ram_in=0, ram_load=0, ram_address=0, busy=0, done=0, err_count=0, first_err_addr=0 and err_flag=0.
REQ-035 Reset asserted mid-pass SHALL stop writes immediately, and no done pulse SHALL follow the release of reset.

Configuration
REQ-036 When RAM512_SWEEP_VERIFY_EN is defined, VERIFY mode and the error logic SHALL be implemented as specified above.
REQ-037 When RAM512_SWEEP_VERIFY_EN is undefined, the verify input SHALL be ignored, every pass SHALL be FILL, and err_count, first_err_addr and err_flag SHALL be constant 0.

Verification
REQ-038 Fill with seed=0x0000 and incr=1, then read back -> RAM[i]=i for i=0..511, busy high for 512 cycles, done pulsed once at cycle 513.
REQ-039 Fill with seed=0xFFF0 and incr=1 -> RAM[0]=0xFFF0, RAM[16]=0x0000, RAM[511]=0x01EF (16-bit wrap).
REQ-040 Fill constant 0xA5A5, corrupt RAM[37] and RAM[200] externally, then verify constant 0xA5A5 -> err_count=2, first_err_addr=37, err_flag=1.
REQ-041 Abort asserted at index 100 of a fill of 0x1234 over a prior fill of 0 -> RAM[0..99]=0x1234, RAM[100..511]=0, no done pulse, busy low at the next edge.
REQ-042 Start pulsed during busy, and RST_N dropped at index 300 -> the extra start has no effect; all outputs go to 0 immediately on reset; no done pulse after reset release.

Source files
------------

// File: rtl/ram512_sweep_ctrl.sv
// ram512_sweep_ctrl: sweeps a RAM512 once per pass, writing or checking a constant or incrementing pattern.
// Define RAM512_SWEEP_VERIFY_EN to build the verify pass and the error counters.
module ram512_sweep_ctrl #(
   parameter int DEPTH  = 512,
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 9
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic              abort,
   input  logic              verify,
   input  logic              incr,
   input  logic [WIDTH-1:0]  seed,
   input  logic [WIDTH-1:0]  ram_out,
   output logic [WIDTH-1:0]  ram_in,
   output logic              ram_load,
   output logic [ADDR_W-1:0] ram_address,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              err_flag
);
   typedef enum logic [1:0] {IDLE, FILL, VERIFY, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              incr_q;
   logic [WIDTH-1:0]  seed_q;
   logic [WIDTH-1:0]  expected;
   logic              accept;
   logic              last;
   logic              go_verify;

   assign expected    = incr_q ? seed_q + WIDTH'(idx) : seed_q;
   assign accept      = state == IDLE && start && !abort;
   assign last        = idx == ADDR_W'(DEPTH - 1);
   assign busy        = state == FILL || state == VERIFY;
   assign done        = state == DONE;
   assign ram_address = idx;
   assign ram_in      = busy ? expected : '0;
   // abort suppresses the write in the very cycle it is raised
   assign ram_load    = state == FILL && !abort;
   assign err_flag    = |err_count;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state  <= IDLE;
         idx    <= '0;
         incr_q <= 1'b0;
         seed_q <= '0;
      end else begin
         case (state)
            IDLE:
               if (accept) begin
                  state  <= go_verify ? VERIFY : FILL;
                  idx    <= '0;
                  incr_q <= incr;
                  seed_q <= seed;
               end
            FILL, VERIFY:
               if (abort || last) begin
                  state <= abort ? IDLE : DONE;
                  idx   <= '0;
               end else
                  idx <= idx + ADDR_W'(1);
            default:
               state <= IDLE;
         endcase
      end

`ifdef RAM512_SWEEP_VERIFY_EN
   assign go_verify = verify;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (accept) begin
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (state == VERIFY && ram_out != expected) begin
         err_count <= err_count + (ADDR_W + 1)'(1);
         if (err_count == '0)
            first_err_addr <= idx;
      end
`else
   logic unused_verify_path;

   assign go_verify          = 1'b0;
   assign err_count          = '0;
   assign first_err_addr     = '0;
   assign unused_verify_path = ^{verify, ram_out};
`endif
endmodule
